// File: rtl/mux12_rr_arbiter_if.sv
// Beat handshake bundle between 12 requesters / downstream consumer and the arbiter.
// master: requester/consumer side; slave: arbiter side.
interface mux12_rr_arbiter_if;
    logic [11:0] req;
    logic [11:0] lock;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  sel;
    logic [11:0] grant;

    modport master (
        output req, lock, out_ready,
        input  out_valid, sel, grant
    );

    modport slave (
        input  req, lock, out_ready,
        output out_valid, sel, grant
    );
endinterface

// File: rtl/mux12_rr_arbiter.sv
// 12-way round-robin arbiter driving a shared mux select, with locked tenures capped at MAX_HOLD beats.
// Optional stall counter output enabled by defining MUX12_RR_ARBITER_PERF_EN.
module mux12_rr_arbiter #(
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    mux12_rr_arbiter_if.slave  bus
`ifdef MUX12_RR_ARBITER_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    localparam logic [CNT_W:0] HOLD_LIM = (CNT_W + 1)'(MAX_HOLD);

    state_t             r_state;
    logic [3:0]         r_ptr;
    logic [3:0]         r_sel;
    logic [11:0]        r_grant;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [3:0]         w_next_ptr;
    logic [3:0]         w_scan_ptr;
    logic [11:0]        w_cand;
    logic               w_cont;
    logic               w_found;
    logic [3:0]         w_win;
    logic [4:0]         w_idx;

    // On acceptance the scan restarts past the current holder and excludes it,
    // since its req is still high during the acceptance cycle.
    always_comb begin
        w_accept   = (r_state == S_GRANT) && bus.out_ready;
        w_next_ptr = (r_sel == 4'd11) ? 4'd0 : r_sel + 4'd1;
        w_scan_ptr = w_accept ? w_next_ptr : r_ptr;
        w_cand     = bus.req & ~(w_accept ? r_grant : '0);
        w_cont     = bus.lock[r_sel] && bus.req[r_sel] &&
                     (({1'b0, r_cnt} + (CNT_W + 1)'(1)) < HOLD_LIM);
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < 12; k++) begin
            w_idx = 5'(w_scan_ptr) + 5'(k);
            if (w_idx >= 5'd12) begin
                w_idx = w_idx - 5'd12;
            end
            if (!w_found && w_cand[w_idx[3:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_valid <= 1'b1;
                        r_sel   <= w_win;
                        r_grant <= 12'b1 << w_win;
                        r_cnt   <= '0;
                    end
                end
                S_GRANT: begin
                    if (!bus.out_ready) begin
                        if (!bus.req[r_sel]) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_sel   <= '0;
                            r_grant <= '0;
                        end
                    end else if (w_cont) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_ptr <= w_next_ptr;
                        r_cnt <= '0;
                        if (w_found) begin
                            r_sel   <= w_win;
                            r_grant <= 12'b1 << w_win;
                        end else begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_sel   <= '0;
                            r_grant <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_sel   <= '0;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;

`ifdef MUX12_RR_ARBITER_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall <= '0;
        end else if (r_valid && !bus.out_ready && (r_stall != '1)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_mux12_rr_arbiter.sv
// Bench for mux12_rr_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a holder/pointer reference model.
module tb_mux12_rr_arbiter;

    localparam int unsigned MAXH = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    mux12_rr_arbiter_if bus();

`ifdef MUX12_RR_ARBITER_PERF_EN
    logic [15:0] stall_cnt;
`endif

    mux12_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus)
`ifdef MUX12_RR_ARBITER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the mux (-1 = nobody), rotation start, beats in tenure.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_cnt    = 0;
    int m_stall  = 0;

    typedef struct {
        bit          rst;
        logic [11:0] req;
        logic [11:0] lock;
        logic        rdy;
        logic        v;
        logic [3:0]  sel;
        logic [11:0] g;
        int          st;
    } vec_t;

    vec_t tbl[$];

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    function automatic int pick(logic [11:0] r, int start, int excl);
        for (int k = 0; k < 12; k++) begin
            int i;
            i = (start + k) % 12;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_holder = -1;
        m_ptr    = 0;
        m_cnt    = 0;
        m_stall  = 0;
    endfunction

    function automatic void m_step(logic [11:0] r, logic [11:0] lk, logic rdy);
        if (m_holder >= 0 && !rdy && m_stall < 65535) m_stall++;
        if (m_holder < 0) begin
            m_holder = pick(r, m_ptr, -1);
            m_cnt    = 0;
        end else if (!rdy) begin
            if (!r[m_holder]) m_holder = -1;
        end else if (lk[m_holder] && r[m_holder] && (m_cnt + 1 < int'(MAXH))) begin
            m_cnt++;
        end else begin
            m_ptr    = (m_holder + 1) % 12;
            m_holder = pick(r, m_ptr, m_holder);
            m_cnt    = 0;
        end
    endfunction

    task automatic cyc(input logic [11:0] r, input logic [11:0] lk, input logic rdy);
        bus.req       = r;
        bus.lock      = lk;
        bus.out_ready = rdy;
        @(posedge clk);
        m_step(r, lk, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic        ev;
        logic [3:0]  es;
        logic [11:0] eg;
        ev = (m_holder >= 0);
        es = ev ? 4'(m_holder) : 4'd0;
        eg = ev ? (12'b1 << m_holder) : 12'd0;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, "_sel"},   32'(bus.sel),       32'(es));
        check({tag, "_grant"}, 32'(bus.grant),     32'(eg));
        check({tag, "_sel_range"}, 32'(bus.sel < 4'd12), 32'd1);
        check({tag, "_onehot0"},   32'($onehot0(bus.grant)), 32'd1);
        check({tag, "_grant_iff_valid"}, 32'(bus.grant != 12'd0), 32'(bus.out_valid));
`ifdef MUX12_RR_ARBITER_PERF_EN
        check({tag, "_stall"}, 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m_reset();
        #2;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sel",   32'(bus.sel),       32'd0);
        check("rst_grant", 32'(bus.grant),     32'd0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    function automatic void add(bit rst, logic [11:0] r, logic [11:0] lk, logic rdy,
                                logic v, logic [3:0] s, logic [11:0] g, int st);
        vec_t x;
        x = '{rst: rst, req: r, lock: lk, rdy: rdy, v: v, sel: s, g: g, st: st};
        tbl.push_back(x);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] r;
        logic [11:0] lk;
        logic        rdy;

        bus.req       = '0;
        bus.lock      = '0;
        bus.out_ready = 1'b0;

        // Single request, accepted then dropped
        add(1, 12'h020, 12'h000, 1'b0, 1'b1, 4'd5, 12'h020, -1);
        add(0, 12'h020, 12'h000, 1'b1, 1'b0, 4'd0, 12'h000, -1);
        add(0, 12'h000, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000, -1);
        // Backpressure holds sel stable, then back-to-back handoff
        add(1, 12'h088, 12'h000, 1'b0, 1'b1, 4'd3, 12'h008, -1);
        add(0, 12'h088, 12'h000, 1'b0, 1'b1, 4'd3, 12'h008, -1);
        add(0, 12'h088, 12'h000, 1'b0, 1'b1, 4'd3, 12'h008, -1);
        add(0, 12'h088, 12'h000, 1'b0, 1'b1, 4'd3, 12'h008, 3);
        add(0, 12'h088, 12'h000, 1'b1, 1'b1, 4'd7, 12'h080, 3);
        add(0, 12'h080, 12'h000, 1'b1, 1'b0, 4'd0, 12'h000, 3);
        // Lock cap at MAX_HOLD=4 beats
        add(1, 12'h204, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h204, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h204, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h204, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h204, 12'h004, 1'b1, 1'b1, 4'd9, 12'h200, -1);
        add(0, 12'h200, 12'h000, 1'b1, 1'b0, 4'd0, 12'h000, -1);
        // Two-beat locked tenure
        add(1, 12'h004, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h004, 12'h004, 1'b1, 1'b1, 4'd2, 12'h004, -1);
        add(0, 12'h004, 12'h000, 1'b1, 1'b0, 4'd0, 12'h000, -1);
        // Abort leaves ptr at 0
        add(1, 12'h010, 12'h000, 1'b0, 1'b1, 4'd4, 12'h010, -1);
        add(0, 12'h000, 12'h000, 1'b0, 1'b0, 4'd0, 12'h000, -1);
        add(0, 12'h3FF, 12'h000, 1'b0, 1'b1, 4'd0, 12'h001, -1);

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            cyc(tbl[i].req, tbl[i].lock, tbl[i].rdy);
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d_sel", i),   32'(bus.sel),       32'(tbl[i].sel));
            check($sformatf("vec%0d_grant", i), 32'(bus.grant),     32'(tbl[i].g));
`ifdef MUX12_RR_ARBITER_PERF_EN
            if (tbl[i].st >= 0)
                check($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].st));
`endif
        end

        // Full rotation with no bubbles
        do_reset();
        for (int k = 0; k < 13; k++) begin
            cyc(12'hFFF, 12'h000, 1'b1);
            check($sformatf("rot%0d_valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("rot%0d_sel", k),   32'(bus.sel),       32'(k % 12));
        end

        // Asynchronous reset in the middle of a tenure
        do_reset();
        cyc(12'h040, 12'h000, 1'b0);
        check("midrst_pre_sel", 32'(bus.sel), 32'd6);
        do_reset();
        cyc(12'h041, 12'h000, 1'b0);
        check("midrst_post_sel",   32'(bus.sel),   32'd0);
        check("midrst_post_grant", 32'(bus.grant), 32'h001);

        // Random traffic against the reference model
        do_reset();
        r = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 1) == 0)
                r = ($urandom_range(0, 7) == 0) ? 12'(~$urandom_range(0, 4095))
                                                 : 12'($urandom) & 12'($urandom);
            lk  = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            cyc(r, lk, rdy);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
